// File: rtl/uart_rx_cfg.sv
// UART receiver with compile-time frame format (data bits, parity, stop bits).
// The serial line is synchronised, sampled mid-bit by a single divider counter,
// and each completed frame is presented on a valid/ready output register. A frame
// that completes while the held word is still unaccepted is dropped and flagged
// on ovr_o.
module uart_rx_cfg #(
  parameter int ClkFreq    = 100000000,
  parameter int Baud       = 9600,
  parameter int DataBits   = 8,
  parameter int ParityMode = 1,
  parameter int StopBits   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  input  logic                ready_i,
  output logic [DataBits-1:0] data_o,
  output logic                valid_o,
  output logic                perr_o,
  output logic                ferr_o,
  output logic                ovr_o,
  output logic                busy_o
);

  // Divider terminal counts: one full bit period, and half a period for the start bit
  localparam int BitCnt  = ClkFreq / Baud - 1;
  localparam int HalfCnt = ClkFreq / (2 * Baud) - 1;
  localparam int CntW    = (BitCnt > 0) ? $clog2(BitCnt + 1) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCnt);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCnt);

  // Bit index is wide enough for up to 9 data bits
  localparam int IdxW = 4;
  localparam logic [IdxW-1:0] DataLast = IdxW'(DataBits - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(StopBits - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [1:0]          sync_reg;
  logic                prev_reg;
  logic                rx_s;
  logic [2:0]          state_reg,  state_next;
  logic [CntW-1:0]     cnt_reg,    cnt_next;
  logic [IdxW-1:0]     idx_reg,    idx_next;
  logic [DataBits-1:0] shift_reg,  shift_next;
  logic                perr_reg,   perr_next;
  logic                ferr_reg,   ferr_next;
  logic                frame_done;
  logic                tick;

  logic [DataBits-1:0] data_reg;
  logic                valid_reg;
  logic                perr_out_reg;
  logic                ferr_out_reg;
  logic                ovr_reg;

  assign rx_s = sync_reg[1];
  assign tick = (cnt_reg == BitLast);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; reset to idle-high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_reg <= 2'b11;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], rx_i};
      prev_reg <= rx_s;
    end
  end

  // Frame sequencing: decides next state, sampling points and per-frame error flags
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CntW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (prev_reg && !rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == HalfLast) begin
          cnt_next = '0;
          if (rx_s) begin
            // Line went back high before mid start bit: treat as a glitch
            state_next = IDLE;
          end else begin
            state_next = DATA;
            idx_next   = '0;
            perr_next  = 1'b0;
            ferr_next  = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DataBits-1:1]};
          if (idx_reg == DataLast) begin
            idx_next   = '0;
            state_next = (ParityMode != 0) ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + IdxW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_next   = '0;
          perr_next  = ((^shift_reg) ^ rx_s) != (ParityMode == 2);
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_next = '0;
          // Only the first stop bit is checked for framing
          if (idx_reg == '0) begin
            ferr_next = !rx_s;
          end
          if (idx_reg == StopLast) begin
            frame_done = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + IdxW'(1);
          end
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      ovr_reg <= 1'b0;
      if (frame_done) begin
        if (valid_reg && !ready_i) begin
          // Held word not yet taken: keep it and drop the new frame
          ovr_reg <= 1'b1;
        end else begin
          data_reg     <= shift_reg;
          perr_out_reg <= perr_reg;
          ferr_out_reg <= ferr_next;
          valid_reg    <= 1'b1;
        end
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign perr_o  = perr_out_reg;
  assign ferr_o  = ferr_out_reg;
  assign ovr_o   = ovr_reg;
  assign busy_o  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 16 clocks per bit, 8E1 format, with a second
// odd-parity instance listening to the same line.
module tb_uart_rx_cfg;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid, perr, ferr, ovr, busy;
  logic [7:0] data_odd;
  logic       valid_odd, perr_odd, ferr_odd, ovr_odd, busy_odd;

  int compares = 0;
  int errors   = 0;

  // Values captured during the stop bit of the most recent frame
  logic v_pre, v_post, busy_pre, odd_valid_post, odd_perr_post;
  logic [7:0] odd_data_post;
  int   ovr_cnt;
  logic saw_busy, saw_valid;

  uart_rx_cfg #(
    .ClkFreq(160), .Baud(10), .DataBits(8), .ParityMode(1), .StopBits(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .ready_i(ready),
    .data_o(data), .valid_o(valid), .perr_o(perr), .ferr_o(ferr),
    .ovr_o(ovr), .busy_o(busy)
  );

  uart_rx_cfg #(
    .ClkFreq(160), .Baud(10), .DataBits(8), .ParityMode(2), .StopBits(1)
  ) dut_odd (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .ready_i(1'b1),
    .data_o(data_odd), .valid_o(valid_odd), .perr_o(perr_odd), .ferr_o(ferr_odd),
    .ovr_o(ovr_odd), .busy_o(busy_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; the stop bit is sampled by the DUT 10 clocks into it,
  // so the output must still be idle at clock 9 and loaded at clock 10.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [9:0] bits;
    bits = {par, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = bits[i];
      repeat (16) @(posedge clk);
    end
    @(negedge clk);
    rx = stp;
    ovr_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (ovr) ovr_cnt++;
      if (c == 9) begin
        v_pre    = valid;
        busy_pre = busy;
      end
      if (c == 10) begin
        v_post         = valid;
        odd_valid_post = valid_odd;
        odd_perr_post  = perr_odd;
        odd_data_post  = data_odd;
      end
    end
    $display("frame data=%02h par=%0b stop=%0b -> valid=%0b data=%02h perr=%0b ferr=%0b ovr_cycles=%0d",
             d, par, stp, valid, data, perr, ferr, ovr_cnt);
  endtask

  // One-cycle handshake; valid must be gone on the following cycle
  task automatic ack(input string tag);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check(tag, valid, 1'b0);
    $display("ack %s -> valid=%0b", tag, valid);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  data,  8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_perr",  perr,  1'b0);
    check("rst_ferr",  ferr,  1'b0);
    check("rst_ovr",   ovr,   1'b0);
    check("rst_busy",  busy,  1'b0);
    $display("reset -> data=%02h valid=%0b busy=%0b", data, valid, busy);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0xA5 has four ones: even parity bit 0
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_busy_mid",  busy_pre, 1'b1);
    check("a5_valid_pre", v_pre,    1'b0);
    check("a5_valid_at",  v_post,   1'b1);
    check("a5_data",      data,     8'hA5);
    check("a5_perr",      perr,     1'b0);
    check("a5_ferr",      ferr,     1'b0);
    ack("a5_ack");

    // 0x01 with parity bit 0: wrong for even, right for odd
    send_frame(8'h01, 1'b0, 1'b1);
    check("p01_valid",     v_post,         1'b1);
    check("p01_data",      data,           8'h01);
    check("p01_perr_even", perr,           1'b1);
    check("p01_odd_valid", odd_valid_post, 1'b1);
    check("p01_odd_data",  odd_data_post,  8'h01);
    check("p01_perr_odd",  odd_perr_post,  1'b0);
    ack("p01_ack");

    // 0x5A with a zero stop bit is still delivered, flagged as framing error
    send_frame(8'h5A, 1'b0, 1'b0);
    check("f5a_valid", v_post, 1'b1);
    check("f5a_data",  data,   8'h5A);
    check("f5a_ferr",  ferr,   1'b1);
    check("f5a_perr",  perr,   1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    ack("f5a_ack");

    // Four-clock low glitch: receiver wakes up then gives up without output
    repeat (4) @(posedge clk);
    @(negedge clk);
    rx = 1'b0;
    saw_busy = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) rx = 1'b1;
      saw_busy  = saw_busy | busy;
      saw_valid = saw_valid | valid;
    end
    check("glitch_busy_rose", saw_busy,  1'b1);
    check("glitch_busy_end",  busy,      1'b0);
    check("glitch_no_valid",  saw_valid, 1'b0);
    $display("glitch -> saw_busy=%0b busy=%0b saw_valid=%0b", saw_busy, busy, saw_valid);

    // Back-to-back frames with the consumer stalled: second one is an overrun
    send_frame(8'h11, 1'b0, 1'b1);
    check("ovr_first_valid", v_post,  1'b1);
    check("ovr_first_data",  data,    8'h11);
    check("ovr_first_noovr", ovr_cnt, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("ovr_held_valid", valid,   1'b1);
    check("ovr_held_data",  data,    8'h11);
    check("ovr_pulse_len",  ovr_cnt, 1);
    ack("ovr_ack");

    // Reset in the middle of data bit 3 of 0x77 aborts the frame
    begin
      logic [7:0] d;
      d = 8'h77;
      @(negedge clk);
      rx = 1'b0;
      repeat (16) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        rx = d[i];
        repeat (16) @(posedge clk);
      end
      @(negedge clk);
      rx = d[3];
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_data",  data,  8'h00);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_perr",  perr,  1'b0);
      check("mid_rst_ferr",  ferr,  1'b0);
      check("mid_rst_ovr",   ovr,   1'b0);
      check("mid_rst_busy",  busy,  1'b0);
      $display("mid-frame reset -> data=%02h valid=%0b busy=%0b", data, valid, busy);
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      saw_busy = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        #1;
        saw_valid = saw_valid | valid;
        saw_busy  = saw_busy | busy;
      end
      check("post_rst_no_valid", saw_valid, 1'b0);
      check("post_rst_no_busy",  saw_busy,  1'b0);
    end

    // 0x3C has four ones: even parity bit 0
    send_frame(8'h3C, 1'b0, 1'b1);
    check("r3c_valid_pre", v_pre,  1'b0);
    check("r3c_valid",     v_post, 1'b1);
    check("r3c_data",      data,   8'h3C);
    check("r3c_perr",      perr,   1'b0);
    check("r3c_ferr",      ferr,   1'b0);
    ack("r3c_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
